// File: rtl/share_zero_fifo.sv
// Zero-sharing FIFO: forms an XOR-to-zero sharing from fresh random words and queues it.
// Define SHARE_ZERO_INTEGRITY_CHECK_EN to enable the sticky head-sharing integrity check.

module share_zero_lane #(
  parameter int NUM_SHARES = 2,
  parameter int NUM_NEEDED = 1,
  parameter int BIT_WIDTH  = 8,
  parameter int IDX        = 0
) (
  input  logic [NUM_NEEDED-1:0][BIT_WIDTH-1:0] words,
  output logic [BIT_WIDTH-1:0]                 share
);
  generate
    if (NUM_SHARES == 2) begin : g_two
      assign share = words[0];
    end else if (NUM_SHARES == 3) begin : g_three
      if (IDX == 2) begin : g_mix
        assign share = words[0] ^ words[1];
      end else begin : g_pass
        assign share = words[IDX];
      end
    end else begin : g_ring
      // Each word appears in exactly two shares, so the XOR of all shares cancels.
      assign share = words[IDX] ^ words[(IDX + 1) % NUM_SHARES];
    end
  endgenerate
endmodule

module share_zero_fifo #(
  parameter int  NUM_SHARES = 2,
  parameter int  BIT_WIDTH  = 8,
  parameter int  DEPTH      = 4,
  localparam int NUM_NEEDED = (NUM_SHARES == 2) ? 1 : (NUM_SHARES == 3) ? 2 : NUM_SHARES,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                             in_clock,
  input  logic                             in_reset,
  input  logic [NUM_NEEDED*BIT_WIDTH-1:0]  in_random,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]  out_random,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             in_flush,
  output logic [LVL_W-1:0]                 out_level,
  output logic                             out_error
);
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [NUM_NEEDED-1:0][BIT_WIDTH-1:0] words;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] sharing;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] mem [DEPTH];
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] head;
  logic [PTR_W-1:0]                     rd_ptr, wr_ptr;
  logic [LVL_W-1:0]                     level;
  logic                                 head_zero;
  logic                                 push, pop;

  assign words = in_random;

  for (genvar j = 0; j < NUM_SHARES; j++) begin : g_lane
    share_zero_lane #(
      .NUM_SHARES(NUM_SHARES),
      .NUM_NEEDED(NUM_NEEDED),
      .BIT_WIDTH (BIT_WIDTH),
      .IDX       (j)
    ) u_lane (
      .words(words),
      .share(sharing[j])
    );
  end

  assign in_ready  = (level < LVL_MAX);
  assign out_valid = (level != '0);
  assign out_level = level;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Storage is intentionally left unreset; the head is masked until the first push.
  always_ff @(posedge in_clock) begin
    if (push && !in_flush) mem[wr_ptr] <= sharing;
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      head_zero <= 1'b1;
    end else if (in_flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= bump(wr_ptr);
        head_zero <= 1'b0;
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign out_random = head_zero ? '0 : head;

`ifdef SHARE_ZERO_INTEGRITY_CHECK_EN
  logic [BIT_WIDTH-1:0] head_xor;
  logic                 err_q;

  always_comb begin
    head_xor = '0;
    for (int j = 0; j < NUM_SHARES; j++) head_xor = head_xor ^ head[j];
  end

  // Sticky until reset; flush deliberately leaves it set.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset)                      err_q <= 1'b0;
    else if (out_valid && (|head_xor))  err_q <= 1'b1;
  end

  assign out_error = err_q;
`else
  assign out_error = 1'b0;
`endif
endmodule

// File: tb/tb_share_zero_fifo.sv
// Directed bench for share_zero_fifo: sharing formation (2/3/4 shares), ordering, full/empty,
// flush priority and asynchronous reset.

module tb_share_zero_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 3 shares, depth 4
  logic [15:0] r3 = '0;
  logic        v3 = 1'b0, or3 = 1'b0, ir3, ov3, err3;
  logic [23:0] o3;
  logic [2:0]  lvl3;

  // Formation-only instances
  logic [31:0] r4 = '0;
  logic        v4 = 1'b0, ir4, ov4, err4;
  logic [31:0] o4;
  logic [2:0]  lvl4;
  logic [7:0]  r2 = '0;
  logic        v2 = 1'b0, ir2, ov2, err2;
  logic [15:0] o2;
  logic [2:0]  lvl2;

  share_zero_fifo #(.NUM_SHARES(3), .BIT_WIDTH(8), .DEPTH(4)) dut3 (
    .in_clock(clk), .in_reset(rst_n), .in_random(r3), .in_valid(v3), .in_ready(ir3),
    .out_random(o3), .out_valid(ov3), .out_ready(or3), .in_flush(flush),
    .out_level(lvl3), .out_error(err3));

  share_zero_fifo #(.NUM_SHARES(4), .BIT_WIDTH(8), .DEPTH(4)) dut4 (
    .in_clock(clk), .in_reset(rst_n), .in_random(r4), .in_valid(v4), .in_ready(ir4),
    .out_random(o4), .out_valid(ov4), .out_ready(1'b0), .in_flush(1'b0),
    .out_level(lvl4), .out_error(err4));

  share_zero_fifo dut2 (
    .in_clock(clk), .in_reset(rst_n), .in_random(r2), .in_valid(v2), .in_ready(ir2),
    .out_random(o2), .out_valid(ov2), .out_ready(1'b0), .in_flush(1'b0),
    .out_level(lvl2), .out_error(err2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry k of the streaming tests: word0 = 0x11*(k+1), word1 = 0xC3+k
  function automatic logic [15:0] wd(input int k);
    return {8'(8'hC3 + k), 8'(8'h11 * (k + 1))};
  endfunction

  function automatic logic [23:0] exp3(input logic [15:0] r);
    return {r[7:0] ^ r[15:8], r[15:8], r[7:0]};
  endfunction

  task automatic push3(input int k);
    v3 = 1'b1;
    r3 = wd(k);
    tick();
    v3 = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_level", lvl3, 0);
    chk("rst_valid", ov3, 0);
    chk("rst_ready", ir3, 1);
    chk("rst_out",   o3, 0);
    chk("rst_err",   err3, 0);
    rst_n = 1'b1;
    tick();

    // Sharing formation, one-cycle latency
    v3 = 1'b1; r3 = {8'h3C, 8'h5A};
    v4 = 1'b1; r4 = 32'h0804_0201;
    v2 = 1'b1; r2 = 8'hA7;
    tick();
    v3 = 1'b0; v4 = 1'b0; v2 = 1'b0;
    chk("s3_valid", ov3, 1);
    chk("s3_shares", o3, 24'h663C5A);
    chk("s3_level", lvl3, 1);
    chk("s4_valid", ov4, 1);
    chk("s4_shares", o4, 32'h090C_0603);
    chk("s4_xor", o4[7:0] ^ o4[15:8] ^ o4[23:16] ^ o4[31:24], 0);
    chk("s2_shares", o2, 16'hA7A7);
    chk("s2_level", lvl2, 1);

    or3 = 1'b1;
    tick();
    or3 = 1'b0;
    chk("pop_level", lvl3, 0);
    chk("pop_valid", ov3, 0);
    or3 = 1'b1;
    tick();
    or3 = 1'b0;
    chk("empty_pop_level", lvl3, 0);

    // Fill past full with pointers starting mid-array, then drain in order
    v3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r3 = wd(k);
      tick();
      chk("fill_level", lvl3, (k < 4) ? k + 1 : 4);
      chk("fill_ready", ir3, (k < 3) ? 1 : 0);
    end
    v3 = 1'b0;
    or3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_head", o3, exp3(wd(k)));
      tick();
    end
    or3 = 1'b0;
    chk("drain_level", lvl3, 0);
    chk("drain_valid", ov3, 0);

    // Full with push+pop: pop only
    for (int k = 0; k < 4; k++) push3(k);
    chk("full_level", lvl3, 4);
    v3 = 1'b1; r3 = wd(4); or3 = 1'b1;
    tick();
    chk("full_pp_level", lvl3, 3);
    chk("full_pp_head", o3, exp3(wd(1)));
    v3 = 1'b0;
    tick();
    chk("pop_to2_level", lvl3, 2);
    v3 = 1'b1; r3 = wd(6);
    tick();
    v3 = 1'b0; or3 = 1'b0;
    chk("half_pp_level", lvl3, 2);
    chk("half_pp_head", o3, exp3(wd(3)));

    // Flush overrides simultaneous push and pop
    flush = 1'b1; v3 = 1'b1; r3 = wd(9); or3 = 1'b1;
    tick();
    flush = 1'b0; v3 = 1'b0; or3 = 1'b0;
    chk("flush_level", lvl3, 0);
    chk("flush_valid", ov3, 0);
    chk("flush_ready", ir3, 1);
    push3(7);
    chk("post_flush_level", lvl3, 1);
    chk("post_flush_head", o3, exp3(wd(7)));

    // Asynchronous reset mid-stream
    push3(8);
    push3(9);
    chk("pre_rst_level", lvl3, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", lvl3, 0);
    chk("arst_valid", ov3, 0);
    chk("arst_ready", ir3, 1);
    chk("arst_out", o3, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", lvl3, 0);
    push3(10);
    chk("post_rst_valid", ov3, 1);
    chk("post_rst_head", o3, exp3(wd(10)));
    chk("err3", err3, 0);
    chk("err4", err4, 0);
    chk("err2", err2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
